multicycle_control: RTL and testbench

Multi-cycle control unit for the RV32I core. It replaces the single-cycle opcode decoder with a state machine that sequences fetch, decode, execute, memory and writeback over several clocks. It drives the shared-memory, single-ALU datapath and covers loads, stores, R-type, I-type ALU, BEQ/BNE and JAL. An optional ready handshake stalls on slow memory, and unsupported encodings are trapped.

---
 rtl/multicycle_control.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared-memory, single-ALU datapath; unsupported encodings trap.
module multicycle_control #(
    parameter int ALU_CTRL_W    = 3,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            op_code,
    input  logic [2:0]            func3,
    input  logic [6:0]            func7,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  ir_write,
    output logic                  adr_source,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic [2:0]            imm_type,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            result_source,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal,
    output logic [3:0]            state_o
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd11;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    logic [3:0] state, state_nx;
    logic       rdy;
    logic       f3_ok;
    logic       br_ok;
    logic [2:0] alu_dec;
    logic [2:0] alu3;
    logic       pcw, irw, rw, mw;
    logic       unused_func7;

    assign rdy          = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign unused_func7 = ^{func7[6], func7[4:0]};
    assign f3_ok = (func3 == 3'b000) || (func3 == 3'b010)
                || (func3[2:1] == 2'b11);
    assign br_ok = (func3[2:1] == 2'b00);

    always_comb begin
        alu_dec = 3'b111;
        unique case (func3)
            3'b000: alu_dec = {2'b00, (state == S_EXECR) & func7[5]};
            3'b010: alu_dec = 3'b101;
            3'b110: alu_dec = 3'b011;
            3'b111: alu_dec = 3'b010;
            default: alu_dec = 3'b111;
        endcase
    end

    always_comb begin
        imm_type = 3'b000;
        unique case (op_code)
            OP_STORE: imm_type = 3'b001;
            OP_BR:    imm_type = 3'b010;
            OP_JAL:   imm_type = 3'b011;
            default:  imm_type = 3'b000;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:  if (rdy) state_nx = S_DECODE;
            S_DECODE: begin
                unique case (op_code)
                    OP_LOAD, OP_STORE: state_nx = S_MEMADR;
                    OP_R:    state_nx = S_EXECR;
                    OP_I:    state_nx = S_EXECI;
                    OP_BR:   state_nx = S_BRANCH;
                    OP_JAL:  state_nx = S_JAL;
                    default: state_nx = S_TRAP;
                endcase
            end
            S_MEMADR: state_nx = (op_code == OP_STORE) ? S_MEMWRITE
                                                       : S_MEMREAD;
            S_MEMREAD:  if (rdy) state_nx = S_MEMWB;
            S_MEMWRITE: if (rdy) state_nx = S_FETCH;
            S_MEMWB:    state_nx = S_FETCH;
            S_EXECR, S_EXECI: state_nx = f3_ok ? S_ALUWB : S_TRAP;
            S_ALUWB:  state_nx = S_FETCH;
            S_BRANCH: state_nx = br_ok ? S_FETCH : S_TRAP;
            S_JAL:    state_nx = S_ALUWB;
            S_TRAP:   state_nx = S_TRAP;
            default:  state_nx = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nx;
    end

    always_comb begin
        pcw           = 1'b0;
        irw           = 1'b0;
        rw            = 1'b0;
        mw            = 1'b0;
        adr_source    = 1'b0;
        mem_read      = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        result_source = 2'b00;
        alu3          = 3'b000;
        case (state)
            S_FETCH: begin
                mem_read      = 1'b1;
                alu_src_b     = 2'b10;
                result_source = 2'b10;
                pcw           = rdy;
                irw           = rdy;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                adr_source = 1'b1;
                mem_read   = 1'b1;
            end
            S_MEMWRITE: begin
                adr_source = 1'b1;
                mw         = 1'b1;
            end
            S_MEMWB: begin
                result_source = 2'b01;
                rw            = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu3      = alu_dec;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu3      = alu_dec;
            end
            S_ALUWB: rw = 1'b1;
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu3      = 3'b001;
                // Branch target was latched into ALUOut during DECODE
                pcw = (func3 == 3'b000) ? zero
                    : (func3 == 3'b001) ? ~zero : 1'b0;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pcw       = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_write    = pcw & rst_n;
    assign ir_write    = irw & rst_n;
    assign reg_write   = rw & rst_n;
    assign mem_write   = mw & rst_n;
    assign alu_control = ALU_CTRL_W'(alu3);
    assign illegal     = (state == S_TRAP);
    assign state_o     = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: vector table, corner sequences
// and random instruction streams against a trace-building reference model.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op_code = 7'b0000011;
    logic [2:0] func3 = 3'b000;
    logic [6:0] func7 = 7'b0000000;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    logic       pc_write, ir_write, adr_source, mem_read;
    logic       mem_write, reg_write, illegal;
    logic [2:0] imm_type, alu_control;
    logic [1:0] alu_src_a, alu_src_b, result_source;
    logic [3:0] state_o;

    logic       pc_write0, ir_write0, adr_source0, mem_read0;
    logic       mem_write0, reg_write0, illegal0;
    logic [2:0] imm_type0, alu_control0;
    logic [1:0] alu_src_a0, alu_src_b0, result_source0;
    logic [3:0] state_o0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multicycle_control #(.ALU_CTRL_W(3), .MEM_HANDSHAKE(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .op_code(op_code), .func3(func3),
        .func7(func7), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .adr_source(adr_source),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .imm_type(imm_type), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_source(result_source), .alu_control(alu_control),
        .illegal(illegal), .state_o(state_o)
    );

    multicycle_control #(.ALU_CTRL_W(3), .MEM_HANDSHAKE(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .op_code(op_code), .func3(func3),
        .func7(func7), .zero(zero), .mem_ready(1'b0),
        .pc_write(pc_write0), .ir_write(ir_write0),
        .adr_source(adr_source0), .mem_read(mem_read0),
        .mem_write(mem_write0), .reg_write(reg_write0),
        .imm_type(imm_type0), .alu_src_a(alu_src_a0),
        .alu_src_b(alu_src_b0), .result_source(result_source0),
        .alu_control(alu_control0), .illegal(illegal0), .state_o(state_o0)
    );

    logic [22:0] act1, act0;
    assign act1 = {pc_write, ir_write, adr_source, mem_read, mem_write,
                   reg_write, imm_type, alu_src_a, alu_src_b, result_source,
                   alu_control, illegal, state_o};
    assign act0 = {pc_write0, ir_write0, adr_source0, mem_read0, mem_write0,
                   reg_write0, imm_type0, alu_src_a0, alu_src_b0,
                   result_source0, alu_control0, illegal0, state_o0};

    // Expected output word for a given phase, from the per-phase tables
    function automatic logic [22:0] exp_out(
        input logic [3:0] st, input logic [6:0] op, input logic [2:0] f3,
        input logic [6:0] f7, input logic z, input logic rdy,
        input logic rst);
        logic pcw, irw, adr, mr, mw, rw, ill;
        logic [2:0] imm, alu;
        logic [1:0] sa, sb, rs;
        logic [2:0] dec;
        {pcw, irw, adr, mr, mw, rw, ill} = '0;
        {sa, sb, rs, alu} = '0;
        case (op)
            7'b0100011: imm = 3'b001;
            7'b1100011: imm = 3'b010;
            7'b1101111: imm = 3'b011;
            default:    imm = 3'b000;
        endcase
        case (f3)
            3'b000:  dec = (st == 4'd6 && f7[5]) ? 3'b001 : 3'b000;
            3'b010:  dec = 3'b101;
            3'b110:  dec = 3'b011;
            3'b111:  dec = 3'b010;
            default: dec = 3'b111;
        endcase
        case (st)
            4'd0: begin mr = 1; sb = 2; rs = 2; pcw = rdy; irw = rdy; end
            4'd1: begin sa = 1; sb = 1; end
            4'd2: begin sa = 2; sb = 1; end
            4'd3: begin adr = 1; mr = 1; end
            4'd4: begin rs = 1; rw = 1; end
            4'd5: begin adr = 1; mw = 1; end
            4'd6: begin sa = 2; alu = dec; end
            4'd7: begin sa = 2; sb = 1; alu = dec; end
            4'd8: rw = 1;
            4'd9: begin
                sa = 2; alu = 3'b001;
                pcw = (f3 == 3'b000) ? z : (f3 == 3'b001) ? ~z : 1'b0;
            end
            4'd10: begin sa = 1; sb = 2; pcw = 1; end
            4'd11: ill = 1;
            default: ;
        endcase
        if (!rst) begin pcw = 0; irw = 0; rw = 0; mw = 0; end
        return {pcw, irw, adr, mr, mw, rw, imm, sa, sb, rs, alu, ill, st};
    endfunction

    task automatic chk(input string nm, input logic [22:0] a,
                       input logic [22:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    task automatic step(input logic [3:0] st, input logic rdy,
                        input logic chk0, input string nm);
        mem_ready = rdy;
        #1;
        chk(nm, act1, exp_out(st, op_code, func3, func7, zero, rdy, 1'b1));
        if (chk0)
            chk({nm, "/nohs"}, act0,
                exp_out(st, op_code, func3, func7, zero, 1'b1, 1'b1));
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("reset", act1,
            exp_out(4'd0, op_code, func3, func7, zero, 1'b1, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        z;
        int          n;
        logic [31:0] seq;
        string       nm;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic z, input int n,
                       input logic [31:0] seq, input string nm);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.z = z;
        v.n = n; v.seq = seq; v.nm = nm;
        tv.push_back(v);
    endtask

    typedef struct { logic [3:0] st; logic rdy; } ph_t;

    // Builds the expected phase trace of one instruction with given waits
    task automatic trace(input int cls, input int wf, input int wm,
                         output ph_t q[$]);
        q = {};
        for (int i = 0; i < wf; i++) q.push_back('{4'd0, 1'b0});
        q.push_back('{4'd0, 1'b1});
        q.push_back('{4'd1, 1'($urandom)});
        case (cls)
            0: begin
                q.push_back('{4'd2, 1'($urandom)});
                for (int i = 0; i < wm; i++) q.push_back('{4'd3, 1'b0});
                q.push_back('{4'd3, 1'b1});
                q.push_back('{4'd4, 1'($urandom)});
            end
            1: begin
                q.push_back('{4'd2, 1'($urandom)});
                for (int i = 0; i < wm; i++) q.push_back('{4'd5, 1'b0});
                q.push_back('{4'd5, 1'b1});
            end
            2: begin
                q.push_back('{4'd6, 1'($urandom)});
                q.push_back('{4'd8, 1'($urandom)});
            end
            3: begin
                q.push_back('{4'd7, 1'($urandom)});
                q.push_back('{4'd8, 1'($urandom)});
            end
            4: q.push_back('{4'd9, 1'($urandom)});
            default: begin
                q.push_back('{4'd10, 1'($urandom)});
                q.push_back('{4'd8, 1'($urandom)});
            end
        endcase
    endtask

    initial begin
        logic [6:0] ops[6];
        logic [2:0] alu_f3[4];
        ph_t q[$];
        ops = '{7'b0000011, 7'b0100011, 7'b0110011,
                7'b0010011, 7'b1100011, 7'b1101111};
        alu_f3 = '{3'b000, 3'b010, 3'b110, 3'b111};

        add(7'b0000011, 3'b010, 7'h00, 0, 6, 32'h043210, "load");
        add(7'b0100011, 3'b010, 7'h00, 0, 5, 32'h05210, "store");
        add(7'b0110011, 3'b000, 7'h20, 0, 5, 32'h08610, "r_sub");
        add(7'b0110011, 3'b000, 7'h00, 0, 5, 32'h08610, "r_add");
        add(7'b0110011, 3'b010, 7'h00, 0, 5, 32'h08610, "r_slt");
        add(7'b0110011, 3'b111, 7'h00, 0, 5, 32'h08610, "r_and");
        add(7'b0010011, 3'b110, 7'h00, 0, 5, 32'h08710, "i_or");
        add(7'b0010011, 3'b000, 7'h20, 0, 5, 32'h08710, "i_add_f7");
        add(7'b1100011, 3'b000, 7'h00, 1, 4, 32'h0910, "beq_taken");
        add(7'b1100011, 3'b000, 7'h00, 0, 4, 32'h0910, "beq_not");
        add(7'b1100011, 3'b001, 7'h00, 1, 4, 32'h0910, "bne_not");
        add(7'b1100011, 3'b001, 7'h00, 0, 4, 32'h0910, "bne_taken");
        add(7'b1101111, 3'b000, 7'h00, 0, 5, 32'h08A10, "jal");
        add(7'b1110011, 3'b000, 7'h00, 0, 4, 32'hBB10, "trap_op");
        add(7'b0010011, 3'b001, 7'h00, 0, 4, 32'hB710, "i_f3_001");
        add(7'b0110011, 3'b100, 7'h00, 0, 4, 32'hB610, "r_f3_100");
        add(7'b1100011, 3'b010, 7'h00, 1, 4, 32'hB910, "br_f3_010");

        foreach (tv[i]) begin
            op_code = tv[i].op; func3 = tv[i].f3;
            func7 = tv[i].f7; zero = tv[i].z;
            do_reset();
            for (int k = 0; k < tv[i].n; k++)
                step(tv[i].seq[4*k +: 4], 1'b1, 1'b1, tv[i].nm);
        end

        // Store stalled three cycles in MEMWRITE
        op_code = 7'b0100011; func3 = 3'b010; zero = 1'b0;
        do_reset();
        step(4'd0, 1'b1, 1'b0, "st_wait");
        step(4'd1, 1'b0, 1'b0, "st_wait");
        step(4'd2, 1'b0, 1'b0, "st_wait");
        for (int i = 0; i < 3; i++) step(4'd5, 1'b0, 1'b0, "st_wait");
        step(4'd5, 1'b1, 1'b0, "st_wait");
        step(4'd0, 1'b1, 1'b0, "st_wait");

        // Fetch stall, then R-type with ready ignored outside memory states
        op_code = 7'b0110011; func3 = 3'b110; func7 = 7'h00;
        do_reset();
        step(4'd0, 1'b0, 1'b0, "fetch_wait");
        step(4'd0, 1'b0, 1'b0, "fetch_wait");
        step(4'd0, 1'b1, 1'b0, "fetch_wait");
        step(4'd1, 1'b0, 1'b0, "fetch_wait");
        step(4'd6, 1'b0, 1'b0, "fetch_wait");
        step(4'd8, 1'b0, 1'b0, "fetch_wait");
        step(4'd0, 1'b1, 1'b0, "fetch_wait");

        // Trap holds for 20 cycles, then asynchronous reset clears it
        op_code = 7'b1110011; func3 = 3'b000;
        do_reset();
        step(4'd0, 1'b1, 1'b0, "trap_hold");
        step(4'd1, 1'b1, 1'b0, "trap_hold");
        for (int i = 0; i < 20; i++)
            step(4'd11, 1'($urandom), 1'b0, "trap_hold");
        mem_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk("trap_clear", act1,
               exp_out(4'd0, op_code, func3, func7, zero, 1'b1, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        step(4'd0, 1'b1, 1'b0, "after_trap");

        // Reset during MEMWB kills the pending register write at once
        op_code = 7'b0000011; func3 = 3'b010;
        do_reset();
        step(4'd0, 1'b1, 1'b0, "mid_rst");
        step(4'd1, 1'b1, 1'b0, "mid_rst");
        step(4'd2, 1'b1, 1'b0, "mid_rst");
        step(4'd3, 1'b1, 1'b0, "mid_rst");
        #1 chk("mid_rst_wb", act1,
               exp_out(4'd4, op_code, func3, func7, zero, 1'b1, 1'b1));
        #1 rst_n = 1'b0;
        #1 chk("mid_rst_abort", act1,
               exp_out(4'd0, op_code, func3, func7, zero, 1'b1, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        step(4'd0, 1'b1, 1'b0, "mid_rst_refetch");

        // Random legal instruction stream with random memory waits
        do_reset();
        for (int n = 0; n < 150; n++) begin
            int cls;
            cls = int'($urandom_range(0, 5));
            op_code = ops[cls];
            func7 = 7'($urandom);
            zero = 1'($urandom);
            if (cls == 4) func3 = 3'($urandom_range(0, 1));
            else func3 = alu_f3[$urandom_range(0, 3)];
            trace(cls, int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 2)), q);
            foreach (q[k]) step(q[k].st, q[k].rdy, 1'b0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
